// File: rtl/i2s_rx_pkg.sv
// Shared types for the I2S slave receiver: FSM states, FIFO sample record, channel codes.
package i2s_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        SHIFT
    } rx_state_e;

    typedef struct packed {
        logic        chan;
        logic [31:0] data;
    } rx_sample_t;

    localparam logic CHAN_LEFT  = 1'b0;
    localparam logic CHAN_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_if.sv
// Read-side bus of the I2S receiver: FIFO head, pop strobe, interrupt and overflow status.
interface i2s_rx_if;

    logic        rd_en_i;
    logic [31:0] rx_dat_o;
    logic        rx_chan_o;
    logic        rx_valid_o;
    logic        rx_int_o;
    logic        ovf_o;
    logic        ovf_clr_i;

    modport slave (
        input  rd_en_i,
        input  ovf_clr_i,
        output rx_dat_o,
        output rx_chan_o,
        output rx_valid_o,
        output rx_int_o,
        output ovf_o
    );

    modport master (
        output rd_en_i,
        output ovf_clr_i,
        input  rx_dat_o,
        input  rx_chan_o,
        input  rx_valid_o,
        input  rx_int_o,
        input  ovf_o
    );

endinterface

// File: rtl/i2s_rx_fifo.sv
// Show-ahead sample FIFO; pointers carry an extra wrap bit so full/empty need no counter.
module i2s_rx_fifo
    import i2s_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       push,
    input  rx_sample_t wr_data,
    input  logic       pop,
    output rx_sample_t rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    rx_sample_t  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop frees the slot in the same cycle, so a push at full still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (do_push)
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

    // Head is forced to zero while empty so the outputs read 0 after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/i2s_rx_slave_core.sv
// I2S slave receive front end: oversampled sck/ws/sd, MSB-first deserialiser, sample FIFO.
module i2s_rx_slave_core
    import i2s_rx_pkg::*;
#(
    parameter int DATA_RES   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic     wb_clk_i,
    input  logic     wb_rst_i,
    input  logic     rx_en_i,
    input  logic     i2s_sck_i,
    input  logic     i2s_ws_i,
    input  logic     i2s_sd_i,
    i2s_rx_if.slave  rx_bus
);

    localparam int CNT_W = $clog2(DATA_RES + 1);

    logic [2:0]          pin_in;
    logic [2:0]          pin_sync;
    logic                sck_s3_reg;
    logic                sck_rise;
    logic                ws_s;
    logic                sd_s;
    logic                boundary;

    rx_state_e           state_reg, state_next;
    logic                ws_prev_reg;
    logic [DATA_RES-1:0] shreg_reg, shreg_next, shreg_ins;
    logic [CNT_W-1:0]    bitcnt_reg, bitcnt_next;
    logic                chan_reg, chan_next;
    logic                push;
    rx_sample_t          wr_sample;
    rx_sample_t          rd_sample;
    logic                fifo_full;
    logic                fifo_empty;
    logic                ovf_set;
    logic                rx_int_reg;
    logic                ovf_reg;

    assign pin_in = {i2s_sck_i, i2s_ws_i, i2s_sd_i};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        logic s1_reg;
        logic s2_reg;
        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                s1_reg <= 1'b0;
                s2_reg <= 1'b0;
            end else begin
                s1_reg <= pin_in[gi];
                s2_reg <= s1_reg;
            end
        end
        assign pin_sync[gi] = s2_reg;
    end

    assign sck_rise = pin_sync[2] & ~sck_s3_reg;
    assign ws_s     = pin_sync[1];
    assign sd_s     = pin_sync[0];
    assign boundary = sck_rise & (ws_s != ws_prev_reg);

    // Current shift register with the incoming bit placed; bits past DATA_RES fall off.
    always_comb begin
        shreg_ins = shreg_reg;
        for (int i = 0; i < DATA_RES; i++) begin
            if (bitcnt_reg == CNT_W'(DATA_RES - 1 - i))
                shreg_ins[i] = sd_s;
        end
    end

    always_comb begin
        state_next  = state_reg;
        shreg_next  = shreg_reg;
        bitcnt_next = bitcnt_reg;
        chan_next   = chan_reg;
        push        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_en_i)
                    state_next = SYNC;
            end
            SYNC: begin
                if (boundary) begin
                    shreg_next  = '0;
                    bitcnt_next = '0;
                    chan_next   = ws_s;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                if (boundary) begin
                    // Boundary bit is the old word's LSB: commit, then open the next word.
                    push        = 1'b1;
                    shreg_next  = '0;
                    bitcnt_next = '0;
                    chan_next   = ws_s;
                end else if (sck_rise) begin
                    shreg_next = shreg_ins;
                    if (bitcnt_reg < CNT_W'(DATA_RES))
                        bitcnt_next = bitcnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        if (!rx_en_i) begin
            state_next = IDLE;
            push       = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg   <= IDLE;
            sck_s3_reg  <= 1'b0;
            ws_prev_reg <= 1'b0;
            shreg_reg   <= '0;
            bitcnt_reg  <= '0;
            chan_reg    <= CHAN_LEFT;
            rx_int_reg  <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sck_s3_reg  <= pin_sync[2];
            if (sck_rise)
                ws_prev_reg <= ws_s;
            shreg_reg   <= shreg_next;
            bitcnt_reg  <= bitcnt_next;
            chan_reg    <= chan_next;
            rx_int_reg  <= ~fifo_empty & rx_en_i;
            if (ovf_set)
                ovf_reg <= 1'b1;
            else if (rx_bus.ovf_clr_i)
                ovf_reg <= 1'b0;
        end
    end

    always_comb begin
        wr_sample                    = '0;
        wr_sample.chan               = chan_reg;
        wr_sample.data[DATA_RES-1:0] = shreg_ins;
    end

    // A same-cycle pop makes room, so only an unserviced push at full is an overflow.
    assign ovf_set = push & fifo_full & ~rx_bus.rd_en_i;

    i2s_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .push     (push),
        .wr_data  (wr_sample),
        .pop      (rx_bus.rd_en_i),
        .rd_data  (rd_sample),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign rx_bus.rx_dat_o   = rd_sample.data;
    assign rx_bus.rx_chan_o  = rd_sample.chan;
    assign rx_bus.rx_valid_o = ~fifo_empty;
    assign rx_bus.rx_int_o   = rx_int_reg;
    assign rx_bus.ovf_o      = ovf_reg;

endmodule

// File: tb/tb_i2s_rx_slave_core.sv
// Directed bench: drives an I2S master at clk/8 and checks the receiver FIFO outputs.
module tb_i2s_rx_slave_core;

    logic clk;
    logic rst;
    logic rx_en;
    logic sck;
    logic ws;
    logic sd;
    int   vectors;
    int   miscompares;

    i2s_rx_if bus();

    i2s_rx_slave_core #(
        .DATA_RES   (16),
        .FIFO_DEPTH (4)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .rx_en_i   (rx_en),
        .i2s_sck_i (sck),
        .i2s_ws_i  (ws),
        .i2s_sd_i  (sd),
        .rx_bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sck period; mode 1 pops on the commit edge, mode 2 watches a commit being popped.
    task automatic send_bit(input logic b_ws, input logic b_sd, input int mode);
        sck = 1'b0;
        ws  = b_ws;
        sd  = b_sd;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        if (mode == 1) begin
            repeat (2) @(negedge clk);
            bus.rd_en_i = 1'b1;
            @(negedge clk);
            bus.rd_en_i = 1'b0;
            @(negedge clk);
        end else if (mode == 2) begin
            repeat (3) @(negedge clk);
            check("t6_valid_on_commit", 32'(bus.rx_valid_o), 32'h1);
            check("t6_data_on_commit", bus.rx_dat_o, 32'h4321);
            check("t6_chan_on_commit", 32'(bus.rx_chan_o), 32'h1);
            check("t6_int_lags", 32'(bus.rx_int_o), 32'h0);
            @(negedge clk);
            check("t6_popped_same_cycle", 32'(bus.rx_valid_o), 32'h0);
            check("t6_int_follows", 32'(bus.rx_int_o), 32'h1);
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic chan, input logic nxt, input logic [31:0] val,
                             input int len, input int lsb_mode);
        for (int i = len - 1; i >= 0; i--)
            send_bit((i == 0) ? nxt : chan, val[i], (i == 0) ? lsb_mode : 0);
    endtask

    task automatic pop_head(input string tag, input logic chan, input logic [31:0] data);
        check({tag, "_valid"}, 32'(bus.rx_valid_o), 32'h1);
        check({tag, "_chan"}, 32'(bus.rx_chan_o), 32'(chan));
        check({tag, "_data"}, bus.rx_dat_o, data);
        bus.rd_en_i = 1'b1;
        @(negedge clk);
        bus.rd_en_i = 1'b0;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        rx_en         = 1'b0;
        sck           = 1'b0;
        ws            = 1'b0;
        sd            = 1'b0;
        bus.rd_en_i   = 1'b0;
        bus.ovf_clr_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dat", bus.rx_dat_o, 32'h0);
        check("rst_chan", 32'(bus.rx_chan_o), 32'h0);
        check("rst_valid", 32'(bus.rx_valid_o), 32'h0);
        check("rst_int", 32'(bus.rx_int_o), 32'h0);
        check("rst_ovf", 32'(bus.ovf_o), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic L/R pair, leading partial word dropped
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b1, 0);
        rx_en = 1'b1;
        @(negedge clk);
        repeat (3) send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b1, 0);
        check("t1_no_partial", 32'(bus.rx_valid_o), 32'h0);
        send_word(1'b0, 1'b1, 32'hA5C3, 16, 0);
        send_word(1'b1, 1'b0, 32'h3C5A, 16, 0);
        check("t1_int", 32'(bus.rx_int_o), 32'h1);
        pop_head("t1_left", 1'b0, 32'hA5C3);
        pop_head("t1_right", 1'b1, 32'h3C5A);
        check("t1_empty", 32'(bus.rx_valid_o), 32'h0);

        // 2: long word truncated, short word MSB-aligned
        send_word(1'b0, 1'b1, 32'h123456, 24, 0);
        send_word(1'b1, 1'b0, 32'hABC, 12, 0);
        pop_head("t2_long", 1'b0, 32'h1234);
        pop_head("t2_short", 1'b1, 32'hABC0);

        // 3: overflow, clear, push+pop at full
        for (int k = 0; k < 6; k++)
            send_word(k[0], ~k[0], 32'h1111 * (k + 1), 16, 0);
        check("t3_ovf_set", 32'(bus.ovf_o), 32'h1);
        for (int k = 0; k < 4; k++)
            pop_head("t3_kept", k[0], 32'h1111 * (k + 1));
        check("t3_lost", 32'(bus.rx_valid_o), 32'h0);
        check("t3_ovf_sticky", 32'(bus.ovf_o), 32'h1);
        bus.ovf_clr_i = 1'b1;
        @(negedge clk);
        bus.ovf_clr_i = 1'b0;
        check("t3_ovf_clr", 32'(bus.ovf_o), 32'h0);
        for (int k = 0; k < 4; k++)
            send_word(k[0], ~k[0], 32'h7001 + k, 16, 0);
        send_word(1'b0, 1'b1, 32'h7005, 16, 1);
        check("t3_no_ovf_pushpop", 32'(bus.ovf_o), 32'h0);
        for (int k = 1; k < 5; k++)
            pop_head("t3_pp", k[0], 32'h7001 + k);
        check("t3_pp_empty", 32'(bus.rx_valid_o), 32'h0);

        // 4: disable mid-word at bit 7, re-enable and resync
        for (int i = 15; i >= 9; i--)
            send_bit(1'b1, 1'(i % 2), 0);
        rx_en = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_no_commit_off", 32'(bus.rx_valid_o), 32'h0);
        rx_en = 1'b1;
        @(negedge clk);
        send_word(1'b1, 1'b0, 32'h1FF, 9, 0);
        check("t4_no_commit_sync", 32'(bus.rx_valid_o), 32'h0);
        send_word(1'b0, 1'b1, 32'hBEEF, 16, 0);
        send_word(1'b1, 1'b0, 32'hCAFE, 16, 0);
        pop_head("t4_left", 1'b0, 32'hBEEF);
        pop_head("t4_right", 1'b1, 32'hCAFE);

        // 5: asynchronous reset mid-word with two entries queued
        send_word(1'b0, 1'b1, 32'h0A0A, 16, 0);
        send_word(1'b1, 1'b0, 32'h0B0B, 16, 0);
        repeat (5) send_bit(1'b0, 1'b1, 0);
        check("t5_queued", 32'(bus.rx_valid_o), 32'h1);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(bus.rx_valid_o), 32'h0);
        check("t5_rst_int", 32'(bus.rx_int_o), 32'h0);
        check("t5_rst_ovf", 32'(bus.ovf_o), 32'h0);
        check("t5_rst_dat", bus.rx_dat_o, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word(1'b0, 1'b1, 32'hFFFF, 11, 0);
        check("t5_no_partial", 32'(bus.rx_valid_o), 32'h0);
        send_word(1'b1, 1'b0, 32'h1357, 16, 0);
        send_word(1'b0, 1'b1, 32'h2468, 16, 0);
        pop_head("t5_right", 1'b1, 32'h1357);
        pop_head("t5_left", 1'b0, 32'h2468);

        // 6: rd_en held while empty
        bus.rd_en_i = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_no_underflow", 32'(bus.rx_valid_o), 32'h0);
        check("t6_empty_dat", bus.rx_dat_o, 32'h0);
        send_word(1'b1, 1'b0, 32'h4321, 16, 2);
        bus.rd_en_i = 1'b0;
        send_word(1'b0, 1'b1, 32'h0F0F, 16, 0);
        pop_head("t6_after", 1'b0, 32'h0F0F);
        check("t6_final_empty", 32'(bus.rx_valid_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
